seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Consumer end of the BCD digit path: takes NUM_DIGITS packed BCD digits from the counter blocks and drives the board's multiplexed, common-anode 7-segment display.
- Time-multiplexes the digits at a fixed refresh rate and decodes BCD to segment patterns.
- Inserts a one-cycle anode dead time at each digit change to prevent ghosting.
- Latches input digits once per full scan frame so a display frame never mixes old and new values.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits/anodes (2..8).
- REFRESH_TICKS, 100_000, clk cycles per digit slot (1 ms at 100 MHz); must be >= 2.
- CNT_W, 17, refresh counter width; must satisfy 2^CNT_W > REFRESH_TICKS-1.

Ports:
- clk  input  1  system clock, 100 MHz on board.
- reset  input  1  asynchronous, active-high reset.
- bcd_in  input  4*NUM_DIGITS  packed digits; digit i = bcd_in[4i+3:4i]; digit 0 is rightmost.
- dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
- digit_en  input  NUM_DIGITS  per-digit enable; 0 keeps that anode off.
- an  output  NUM_DIGITS  anode drive, active-low, registered.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered; seg[0]=a.
- dp  output  1  decimal point cathode, active-low, registered.
- scan_tick  output  1  one-cycle pulse, registered, on each digit advance.

Behaviour:
- Reset (async, active-high) values:
  - cnt=0, idx=0, snapshot=0, scan_tick=0.
  - an=all 1s, seg=7'h7F, dp=1.
- Refresh counter cnt runs 0..REFRESH_TICKS-1.
  - At cnt==REFRESH_TICKS-1: cnt<=0, idx<=(idx==NUM_DIGITS-1)?0:idx+1, scan_tick<=1.
  - All other cycles: cnt<=cnt+1, scan_tick<=0.
- Frame latch: on the edge where idx wraps NUM_DIGITS-1 -> 0, snapshot (digits plus dp_in) <= bcd_in/dp_in.
  - The new frame's digit 0 therefore uses the new data.
  - The first frame after reset displays all zeros.
- digit_en is not latched; it is sampled live every cycle.
- Output register, computed every cycle from current cnt, idx and snapshot (1-cycle latency):
  - If cnt==0 (dead time): an=all 1s, seg=7'h7F, dp=1.
  - Else: an = ~(onehot(idx) & digit_en); seg = decode(snapshot digit idx); dp = ~snapshot_dp[idx].
- Decode:
  - 0-9 give standard patterns, e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000.
  - Illegal codes 10-15 give a dash (g only): 7'b0111111.
- At most one anode is low in any cycle.
- Slot timing: a given anode is low for exactly REFRESH_TICKS-1 cycles per slot.
- Reset mid-slot: all outputs blank immediately (async); after release, scanning restarts at digit 0 with cnt=0.
- bcd_in changes mid-frame: no visible effect until the next frame boundary.

Optional Feature:
- Macro SEG7_LZB_EN enables leading-zero blanking.
- With SEG7_LZB_EN defined:
  - Any snapshot digit that is 0 and has only zero digits above it is blanked (an bit held high).
  - Digit 0 is never blanked.
  - A digit with its dp bit set is never blanked.
  - The blank mask is computed from the snapshot, so it is stable for the whole frame.
- Without the macro: every enabled digit is shown, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - Segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (7'h7F).
  - Localparam for the digit width (4).
  - Function onehot_idx.
- Sub-module bcd_to_seg7: purely combinational 4-bit -> 7-bit decoder using the package constants; instantiated once on the selected snapshot digit.

Test Plan (NUM_DIGITS=4, REFRESH_TICKS=4):
- Reset release, bcd_in=16'h1234 -> first frame (16 cycles) shows 0 on every digit. After the wrap, an sequence per slot is 1111 (dead), then 1110 x3 with seg=7'b0011001 (4); next slot 1101 with seg=7'b0110000 (3).
- scan_tick timing -> pulses once every 4 cycles; the an low pattern rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Change bcd_in from 16'h1234 to 16'h5678 while idx=2 -> digits 2 and 3 still show 2 and 1; the next frame shows 8, 7, 6, 5.
- bcd_in=16'h00AF, dp_in=4'b0010, digit_en=4'b1011 -> digits 0 and 1 show dash; dp low only in the digit 1 slot; the digit 2 slot keeps an=1111 throughout.
- Assert reset while an=1011 -> an=1111, seg=7'h7F and dp=1 in the same cycle; after release, scanning restarts at digit 0.
- With SEG7_LZB_EN, bcd_in=16'h0070 -> digits 3 and 2 blanked, digits 1 and 0 shown as 7 and 0. With bcd_in=16'h0000 -> only digit 0 shows 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (common-anode display).
package seg7_pkg;

   localparam int DIGIT_W    = 4;
   localparam int MAX_DIGITS = 8;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   // Bit 'pos' of the one-hot encoding of 'idx'.
   function automatic logic onehot_idx(input logic [2:0] idx, input logic [2:0] pos);
      return (idx == pos);
   endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; codes 10-15 show a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_bcd,
   output logic [6:0]         o_seg
);

   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-frame digit latch.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int REFRESH_TICKS = 100_000,
   parameter int CNT_W         = 17
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   input  logic [NUM_DIGITS-1:0]         digit_en,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [6:0]                    seg,
   output logic                          dp,
   output logic                          scan_tick
);

   localparam int                IDX_W    = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_TICKS - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]              r_cnt;
   logic [IDX_W-1:0]              r_idx;
   logic [DIGIT_W*NUM_DIGITS-1:0] r_snap_bcd;
   logic [NUM_DIGITS-1:0]         r_snap_dp;
   logic                          r_scan_tick;
   logic [NUM_DIGITS-1:0]         r_an;
   logic [6:0]                    r_seg;
   logic                          r_dp;

   logic                          w_terminal;
   logic                          w_dead;
   logic [DIGIT_W-1:0]            w_digits [NUM_DIGITS];
   logic [DIGIT_W-1:0]            w_sel_bcd;
   logic [6:0]                    w_seg;
   logic [NUM_DIGITS-1:0]         w_onehot;
   logic [NUM_DIGITS-1:0]         w_blank;

   assign w_terminal = (r_cnt == CNT_LAST);
   assign w_dead     = (r_cnt == '0);

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_digits[i] = r_snap_bcd[i*DIGIT_W +: DIGIT_W];
         w_onehot[i] = onehot_idx(3'(r_idx), 3'(i));
      end
   end

   assign w_sel_bcd = w_digits[r_idx];

   bcd_to_seg7 u_dec (
      .i_bcd (w_sel_bcd),
      .o_seg (w_seg)
   );

`ifdef SEG7_LZB_EN
   // Blank zeros above the most significant non-zero digit; digit 0 always shows.
   always_comb begin
      logic w_zero_run;
      w_blank    = '0;
      w_zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         w_zero_run = w_zero_run & (w_digits[i] == '0);
         if (w_zero_run && !r_snap_dp[i]) begin
            w_blank[i] = 1'b1;
         end
      end
   end
`else
   assign w_blank = '0;
`endif

   // Slot timing and frame latch; snapshot refreshes as idx wraps to 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_idx       <= '0;
         r_snap_bcd  <= '0;
         r_snap_dp   <= '0;
         r_scan_tick <= 1'b0;
      end else if (w_terminal) begin
         r_cnt       <= '0;
         r_idx       <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
         r_scan_tick <= 1'b1;
         if (r_idx == IDX_LAST) begin
            r_snap_bcd <= bcd_in;
            r_snap_dp  <= dp_in;
         end
      end else begin
         r_cnt       <= r_cnt + CNT_W'(1);
         r_scan_tick <= 1'b0;
      end
   end

   // First cycle of each slot keeps every anode off to avoid ghosting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_an  <= '1;
         r_seg <= SEG_OFF;
         r_dp  <= 1'b1;
      end else if (w_dead) begin
         r_an  <= '1;
         r_seg <= SEG_OFF;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= ~(w_onehot & digit_en & ~w_blank);
         r_seg <= w_seg;
         r_dp  <= ~r_snap_dp[r_idx];
      end
   end

   assign an        = r_an;
   assign seg       = r_seg;
   assign dp        = r_dp;
   assign scan_tick = r_scan_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4 clocks per slot).
// Expected outputs are queued at each clock edge and compared on the falling edge.
module tb_seg7_scan_driver;

   localparam int ND = 4;
   localparam int RT = 4;
   localparam int CW = 2;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic [15:0] bcd_in   = 16'h1234;
   logic [3:0]  dp_in    = 4'b0000;
   logic [3:0]  digit_en = 4'b1111;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        scan_tick;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       tick;
   } exp_t;

   exp_t        q[$];
   int          m_t = 0;
   logic [15:0] m_snap = 16'h0;
   logic [3:0]  m_sdp  = 4'h0;

   seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_TICKS(RT), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bcd_in    (bcd_in),
      .dp_in     (dp_in),
      .digit_en  (digit_en),
      .an        (an),
      .seg       (seg),
      .dp        (dp),
      .scan_tick (scan_tick)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   function automatic logic [3:0] ref_blank(input logic [15:0] s, input logic [3:0] p);
      logic [3:0] mk;
      mk = 4'b0000;
`ifdef SEG7_LZB_EN
      begin
         logic seen;
         seen = 1'b0;
         for (int d = 3; d >= 1; d--) begin
            if (s[d*4 +: 4] != 4'd0) seen = 1'b1;
            if (!seen && !p[d]) mk[d] = 1'b1;
         end
      end
`endif
      return mk;
   endfunction

   // Reference model: position derived from edges counted since reset release.
   always @(posedge clk) begin
      exp_t       e;
      int         pos;
      int         dg;
      logic [3:0] mk;
      if (reset) begin
         m_t    = 0;
         m_snap = 16'h0;
         m_sdp  = 4'h0;
         e      = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
      end else begin
         pos = m_t % RT;
         dg  = (m_t / RT) % ND;
         mk  = ref_blank(m_snap, m_sdp);
         if (pos == 0) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
         end else begin
            e.an  = ~((4'b0001 << dg) & digit_en & ~mk);
            e.seg = ref_seg(m_snap[dg*4 +: 4]);
            e.dp  = ~m_sdp[dg];
         end
         e.tick = (pos == RT - 1);
         if (pos == RT - 1 && dg == ND - 1) begin
            m_snap = bcd_in;
            m_sdp  = dp_in;
         end
         m_t++;
      end
      q.push_back(e);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input int n);
      exp_t e;
      repeat (n) begin
         @(negedge clk);
         if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed=0 entries expected=1 entry");
         end else begin
            e = q.pop_front();
            chk("sb_an",   32'(an),        32'(e.an));
            chk("sb_seg",  32'(seg),       32'(e.seg));
            chk("sb_dp",   32'(dp),        32'(e.dp));
            chk("sb_tick", 32'(scan_tick), 32'(e.tick));
         end
      end
   endtask

   // Advance until the output produced by edge k (counted from release) is visible.
   task automatic step_to(input int k);
      int guard;
      guard = 0;
      while (m_t <= k && guard < 2000) begin
         step(1);
         guard++;
      end
   endtask

   initial begin
      step(3);
      chk("rst_an",   32'(an),        32'hF);
      chk("rst_seg",  32'(seg),       32'h7F);
      chk("rst_dp",   32'(dp),        32'h1);
      chk("rst_tick", 32'(scan_tick), 32'h0);
      reset = 1'b0;

      step_to(0);
      chk("dead0_an", 32'(an), 32'hF);
      step_to(1);
      chk("f0_d0_an",  32'(an),  32'b1110);
      chk("f0_d0_seg", 32'(seg), 32'h40);
      step_to(5);
`ifdef SEG7_LZB_EN
      chk("f0_d1_an", 32'(an), 32'b1111);
`else
      chk("f0_d1_an",  32'(an),  32'b1101);
      chk("f0_d1_seg", 32'(seg), 32'h40);
`endif
      step_to(15);
      chk("tick_pulse", 32'(scan_tick), 32'h1);
      step_to(16);
      chk("dead_an",   32'(an),        32'hF);
      chk("tick_low",  32'(scan_tick), 32'h0);
      step_to(17);
      chk("f1_d0_an",  32'(an),  32'b1110);
      chk("f1_d0_seg", 32'(seg), 32'b0011001);
      step_to(21);
      chk("f1_d1_an",  32'(an),  32'b1101);
      chk("f1_d1_seg", 32'(seg), 32'b0110000);
      step_to(25);
      chk("f1_d2_an",  32'(an),  32'b1011);
      chk("f1_d2_seg", 32'(seg), 32'h24);
      bcd_in = 16'h5678;
      step_to(26);
      chk("f1_d2_hold", 32'(seg), 32'h24);
      step_to(29);
      chk("f1_d3_an",  32'(an),  32'b0111);
      chk("f1_d3_seg", 32'(seg), 32'h79);
      step_to(33);
      chk("f2_d0_seg", 32'(seg), 32'h00);
      step_to(45);
      chk("f2_d3_an",  32'(an),  32'b0111);
      chk("f2_d3_seg", 32'(seg), 32'h12);

      bcd_in   = 16'h00AF;
      dp_in    = 4'b0010;
      digit_en = 4'b1011;
      step_to(49);
      chk("f3_d0_an",  32'(an),  32'b1110);
      chk("f3_d0_seg", 32'(seg), 32'h3F);
      chk("f3_d0_dp",  32'(dp),  32'h1);
      step_to(53);
      chk("f3_d1_an",  32'(an),  32'b1101);
      chk("f3_d1_seg", 32'(seg), 32'h3F);
      chk("f3_d1_dp",  32'(dp),  32'h0);
      step_to(57);
      chk("f3_d2_off", 32'(an), 32'b1111);
      step_to(59);
      chk("f3_d2_off_end", 32'(an), 32'b1111);

      bcd_in   = 16'h1234;
      dp_in    = 4'b0000;
      digit_en = 4'b1111;
      step_to(73);
      chk("f4_d2_an", 32'(an), 32'b1011);
      #2 reset = 1'b1;
      #1;
      chk("async_an",  32'(an),  32'hF);
      chk("async_seg", 32'(seg), 32'h7F);
      chk("async_dp",  32'(dp),  32'h1);
      step(2);
      reset = 1'b0;
      step_to(1);
      chk("restart_an",  32'(an),  32'b1110);
      chk("restart_seg", 32'(seg), 32'h40);

      bcd_in = 16'h0070;
      step_to(17);
      chk("z_d0_an",  32'(an),  32'b1110);
      chk("z_d0_seg", 32'(seg), 32'h40);
      step_to(21);
      chk("z_d1_an",  32'(an),  32'b1101);
      chk("z_d1_seg", 32'(seg), 32'h78);
      step_to(25);
`ifdef SEG7_LZB_EN
      chk("z_d2_an", 32'(an), 32'b1111);
`else
      chk("z_d2_an", 32'(an), 32'b1011);
`endif
      step_to(29);
`ifdef SEG7_LZB_EN
      chk("z_d3_an", 32'(an), 32'b1111);
`else
      chk("z_d3_an", 32'(an), 32'b0111);
`endif
      bcd_in = 16'h0000;
      step_to(33);
      chk("zz_d0_an",  32'(an),  32'b1110);
      chk("zz_d0_seg", 32'(seg), 32'h40);
      step_to(37);
`ifdef SEG7_LZB_EN
      chk("zz_d1_an", 32'(an), 32'b1111);
`else
      chk("zz_d1_an", 32'(an), 32'b1101);
`endif
      step_to(47);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
